// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_ctrl_pkg                                               |
// | Description : Shared configuration for the fetch controller. Holds the     |
// |               default datapath width, the instruction size and the state   |
// |               encoding of the fetch FSM.                                   |
// | Contents    : c_xpr_len    - default address/instruction width            |
// |               c_inst_bytes - bytes per instruction (pc increment)          |
// |               c_state_w    - width of the fetch state register            |
// |               c_st_*       - fetch state encodings                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

`ifndef XPR_LEN
`define XPR_LEN 32
`endif

package fetch_ctrl_pkg;

  localparam int c_xpr_len    = `XPR_LEN;
  localparam int c_inst_bytes = 4;

  localparam int c_state_w = 3;

  localparam logic [c_state_w-1:0] c_st_req   = 3'd0;  // request on the imem port
  localparam logic [c_state_w-1:0] c_st_wait  = 3'd1;  // waiting for the response
  localparam logic [c_state_w-1:0] c_st_hold  = 3'd2;  // presenting to decode
  localparam logic [c_state_w-1:0] c_st_kill  = 3'd3;  // discard in-flight response
  localparam logic [c_state_w-1:0] c_st_fault = 3'd4;  // misaligned target reported

endpackage

`default_nettype wire

// File: rtl/fetch_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_out_reg                                                |
// | Description : One-entry valid/ready holding register between fetch and    |
// |               decode. Payload only changes on load, so it is stable while |
// |               valid is high and ready is low.                              |
// | Ports       : clk, rst        - clock, asynchronous active-high reset      |
// |               load            - capture in_* and raise valid               |
// |               flush           - drop the held entry (load has priority)    |
// |               in_pc/in_inst/in_fault - entry to capture                    |
// |               ready           - consumer accepts the entry                 |
// |               valid/pc/inst/fault - registered entry to the consumer       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module fetch_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] in_pc,
  input  logic [W-1:0] in_inst,
  input  logic         in_fault,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] pc,
  output logic [W-1:0] inst,
  output logic         fault
);

  logic         r_valid;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_inst;
  logic         r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (load) begin
        // A load in the same cycle as a flush replaces the flushed entry.
        r_valid <= 1'b1;
        r_pc    <= in_pc;
        r_inst  <= in_inst;
        r_fault <= in_fault;
      end else if (flush || (r_valid && ready)) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid = r_valid;
  assign pc    = r_pc;
  assign inst  = r_inst;
  assign fault = r_fault;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_ctrl                                                   |
// | Description : Instruction fetch controller. Keeps at most one imem request |
// |               in flight, presents each fetched instruction to decode via  |
// |               a registered holding stage, and handles redirects from      |
// |               execute, discarding responses that belong to a stale path.  |
// | Ports       : clk, rst                 - clock, async active-high reset    |
// |               redirect_valid/_pc       - new fetch target from execute     |
// |               imem_req_valid/_ready/_addr - imem request channel          |
// |               imem_resp_valid/_data    - in-order imem response            |
// |               if_valid/_ready/_pc/_inst/_fault - output to decode          |
// | Options     : FETCH_CTRL_MISALIGN_EN - when defined, a redirect to an     |
// |               address with [1:0]!=0 is reported as a fault instead of     |
// |               being fetched; otherwise the low bits are forced to zero.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                 XPR_LEN  = c_xpr_len,
  parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(32'h0000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XPR_LEN-1:0] redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XPR_LEN-1:0] imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [XPR_LEN-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XPR_LEN-1:0] if_pc,
  output logic [XPR_LEN-1:0] if_inst,
  output logic               if_fault
);

  localparam logic [XPR_LEN-1:0] c_inc        = XPR_LEN'(c_inst_bytes);
  localparam logic [XPR_LEN-1:0] c_align_mask = XPR_LEN'(c_inst_bytes - 1);

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_nxt;
  logic [XPR_LEN-1:0]   r_pc;
  logic [XPR_LEN-1:0]   w_pc_nxt;

  logic                 w_req_valid;
  logic                 w_accept;

  logic [XPR_LEN-1:0]   w_redir_pc;
  logic                 w_redir_misal;
  logic [XPR_LEN-1:0]   w_kill_tgt;
  logic                 w_kill_misal;

  logic                 w_ld;
  logic                 w_flush;
  logic [XPR_LEN-1:0]   w_ld_pc;
  logic [XPR_LEN-1:0]   w_ld_inst;
  logic                 w_ld_fault;

  // In KILL the target that will be fetched after the drop is the newest
  // redirect, including one arriving in the same cycle as the response.
  assign w_kill_tgt = redirect_valid ? w_redir_pc : r_pc;

`ifdef FETCH_CTRL_MISALIGN_EN
  assign w_redir_pc    = redirect_pc;
  assign w_redir_misal = |(redirect_pc & c_align_mask);
  assign w_kill_misal  = |(w_kill_tgt & c_align_mask);
`else
  // Low bits are cleared so the fault path can never be entered and the
  // fault bit of the holding register only ever loads zero.
  assign w_redir_pc    = redirect_pc & ~c_align_mask;
  assign w_redir_misal = 1'b0;
  assign w_kill_misal  = 1'b0;
`endif

  assign w_accept = w_req_valid && imem_req_ready;

  // State and fetch pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_req;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next state, next pc and holding-register control.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ld        = 1'b0;
    w_flush     = 1'b0;
    w_ld_pc     = r_pc;
    w_ld_inst   = imem_resp_data;
    w_ld_fault  = 1'b0;

    case (r_state)
      c_st_req: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          if (w_accept) begin
            // The request just accepted belongs to the old path.
            w_state_nxt = c_st_kill;
          end else if (w_redir_misal) begin
            w_state_nxt = c_st_fault;
            w_ld        = 1'b1;
            w_ld_pc     = w_redir_pc;
            w_ld_inst   = '0;
            w_ld_fault  = 1'b1;
          end
        end else if (w_accept) begin
          w_state_nxt = c_st_wait;
        end
      end

      c_st_wait: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          if (!imem_resp_valid) begin
            w_state_nxt = c_st_kill;
          end else if (w_redir_misal) begin
            w_state_nxt = c_st_fault;
            w_ld        = 1'b1;
            w_ld_pc     = w_redir_pc;
            w_ld_inst   = '0;
            w_ld_fault  = 1'b1;
          end else begin
            // Same-cycle response is dropped; refetch from the target.
            w_state_nxt = c_st_req;
          end
        end else if (imem_resp_valid) begin
          w_state_nxt = c_st_hold;
          w_ld        = 1'b1;
          w_ld_pc     = r_pc;
          w_pc_nxt    = r_pc + c_inc;
        end
      end

      c_st_hold: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          w_flush  = 1'b1;
          if (w_redir_misal) begin
            w_state_nxt = c_st_fault;
            w_ld        = 1'b1;
            w_ld_pc     = w_redir_pc;
            w_ld_inst   = '0;
            w_ld_fault  = 1'b1;
          end else begin
            w_state_nxt = c_st_req;
          end
        end else if (if_ready) begin
          w_state_nxt = c_st_req;
        end
      end

      c_st_kill: begin
        w_pc_nxt = w_kill_tgt;
        if (imem_resp_valid) begin
          if (w_kill_misal) begin
            w_state_nxt = c_st_fault;
            w_ld        = 1'b1;
            w_ld_pc     = w_kill_tgt;
            w_ld_inst   = '0;
            w_ld_fault  = 1'b1;
          end else begin
            w_state_nxt = c_st_req;
          end
        end
      end

      c_st_fault: begin
        // The fault entry clears itself on the decode handshake; the block
        // then idles here until execute redirects.
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          w_flush  = 1'b1;
          if (w_redir_misal) begin
            w_ld       = 1'b1;
            w_ld_pc    = w_redir_pc;
            w_ld_inst  = '0;
            w_ld_fault = 1'b1;
          end else begin
            w_state_nxt = c_st_req;
          end
        end
      end

      default: begin
        w_state_nxt = c_st_req;
      end
    endcase
  end

  // imem request outputs. Gating with rst keeps the request low for the
  // whole reset window even though the reset state is REQ.
  always_comb begin
    imem_req_valid = (r_state == c_st_req) && !rst;
    imem_req_addr  = r_pc;
  end

  assign w_req_valid = imem_req_valid;

  fetch_out_reg #(
    .W (XPR_LEN)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_ld),
    .flush    (w_flush),
    .in_pc    (w_ld_pc),
    .in_inst  (w_ld_inst),
    .in_fault (w_ld_fault),
    .ready    (if_ready),
    .valid    (if_valid),
    .pc       (if_pc),
    .inst     (if_inst),
    .fault    (if_fault)
  );

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter XPR_LEN, default `XPR_LEN (32), address and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-003 Ports: clk  in  1  sole clock, rising edge.
REQ-004 Ports: rst  in  1  asynchronous, active-high reset.
REQ-005 Ports: redirect_valid  in  1, redirect_pc  in  XPR_LEN; branch/jump/trap target from execute.
REQ-006 Ports: imem_req_valid  out  1, imem_req_ready  in  1, imem_req_addr  out  XPR_LEN; instruction memory request.
REQ-007 Ports: imem_resp_valid  in  1, imem_resp_data  in  XPR_LEN; response, in order, exactly one per accepted request.
REQ-008 Ports: if_valid  out  1, if_ready  in  1, if_pc  out  XPR_LEN, if_inst  out  XPR_LEN, if_fault  out  1; output to decode.

Function
REQ-009 SHALL keep at most one imem request outstanding.
REQ-010 SHALL hold a request transfer until imem_req_valid and imem_req_ready are both high in the same cycle; addr SHALL be stable while valid and not ready.
REQ-011 SHALL use FSM states REQ, WAIT, HOLD, KILL, FAULT.
REQ-012 REQ: imem_req_valid=1, addr=pc_q; on accept go to WAIT.
REQ-013 WAIT: on imem_resp_valid, latch {pc_q, data} into the output register, set if_valid, pc_q+=4, go to HOLD.
REQ-014 HOLD: if_valid=1; on if_ready go to REQ. If pc_q+4 is the next address, a request SHALL issue in the cycle after the handshake, giving a 3-cycle minimum fetch period with a zero-wait memory.
REQ-015 Redirect in REQ, or in REQ with a same-cycle accept: pc_q<=redirect_pc. A same-cycle accept SHALL go to KILL, not WAIT; otherwise stay in REQ.
REQ-016 Redirect in WAIT without a response: go to KILL. In KILL, the next response SHALL be dropped, then go to REQ with pc_q=redirect_pc.
REQ-017 Redirect in WAIT with a same-cycle response: the response SHALL be dropped, pc_q<=redirect_pc, go to REQ.
REQ-018 Redirect in HOLD: clear if_valid in the next cycle regardless of if_ready, pc_q<=redirect_pc, go to REQ.
REQ-019 Redirect in KILL: update the stored target to the latest redirect_pc.
REQ-020 pc_q increment SHALL wrap modulo 2^XPR_LEN (FFFF_FFFC+4 -> 0000_0000).
REQ-021 Outputs if_pc, if_inst and if_fault SHALL be registered and stable while if_valid and not if_ready.

Reset
REQ-022 On rst: state=REQ, pc_q=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_fault=0, kill flag=0.
REQ-023 imem_req_valid SHALL be 0 while rst is high and SHALL go to 1 in the first cycle after deassertion.
REQ-024 Reset while WAIT or KILL SHALL abandon the in-flight response. The memory side guarantees no stale response after reset.

Configuration
REQ-025 Macro FETCH_CTRL_MISALIGN_EN.
REQ-026 When defined: a redirect_pc with [1:0]!=0 SHALL skip the fetch and go to FAULT. FAULT presents if_valid=1, if_fault=1, if_pc=redirect_pc, if_inst=0 and issues no requests. After the handshake the block SHALL idle in FAULT with if_valid=0 until the next redirect.
REQ-027 When undefined: redirect_pc[1:0] SHALL be forced to 00, FAULT is unreachable, and if_fault is tied to 0.

Structure
REQ-028 A shared package/include (BEAN.cfg) SHALL hold XPR_LEN, the FSM state encoding constants and the instruction size of 4.
REQ-029 The output holding register SHALL be a sub-module named fetch_out_reg, a 1-entry valid/ready register with a flush input.

Verification
REQ-030 Reset release, zero-wait memory returning 0x13 (NOP), if_ready=1 -> requests at 0x0, 0x4, 0x8; if_pc sequence 0,4,8; if_inst=0x00000013.
REQ-031 Redirect to 0x100 while in WAIT; old response returns 2 cycles later -> old data is never presented; next request addr=0x100; if_pc=0x100.
REQ-032 if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_inst stable; no imem_req_valid; one request after if_ready=1.
REQ-033 imem_req_ready=0 for 3 cycles -> addr held constant; exactly one accept.
REQ-034 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-035 With FETCH_CTRL_MISALIGN_EN, redirect to 0x102 -> if_fault=1, if_pc=0x102, no imem request until a redirect to 0x200, which resumes fetching at 0x200.
